// File: rtl/oam_dma_arbiter_pkg.sv
// rtl/oam_dma_arbiter_pkg.sv - shared types and constants for the sprite DMA arbiter
//
// Purpose : FSM state encoding, default bus addresses and transfer length for
//           oam_dma_arbiter and its bus mux.
// Ports   : none (package).
package oam_dma_arbiter_pkg;

  localparam logic [15:0] DEF_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;
  localparam int          DEF_XFER_LEN      = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  // The DMA owns the bus from the first dummy/get cycle to the last put cycle.
  // HALT is excluded: the CPU still drives the bus while it winds down.
  function automatic logic dma_owns_bus(input dma_state_t s);
    return (s == ST_ALIGN) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// rtl/oam_dma_bus_mux.sv - combinational CPU/DMA selector for the system bus
//
// Purpose : Chooses address, write data and direction for the system bus from
//           either the CPU core or the DMA sequencer, based on the FSM state.
// Ports   :
//   i_state        in  3   current arbiter state (dma_state_t encoding)
//   i_cpu_addr     in  16  CPU address
//   i_cpu_data_out in  8   CPU write data
//   i_cpu_rw       in  1   CPU direction (1=read)
//   i_page         in  8   latched DMA source page
//   i_idx          in  8   current byte index within the page
//   i_dma_data     in  8   byte captured on the last get cycle
//   o_bus_addr     out 16  arbitrated address
//   o_bus_data_out out 8   arbitrated write data
//   o_bus_rw       out 1   arbitrated direction
module oam_dma_bus_mux
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic [2:0]  i_state,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data_out,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_page,
  input  logic [7:0]  i_idx,
  input  logic [7:0]  i_dma_data,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_data_out,
  output logic        o_bus_rw
);

  dma_state_t w_state;
  assign w_state = dma_state_t'(i_state);

  always_comb begin
    o_bus_addr     = i_cpu_addr;
    o_bus_data_out = i_cpu_data_out;
    o_bus_rw       = i_cpu_rw;
    case (w_state)
      // Alignment burns a cycle as a dummy read of whatever the CPU is addressing.
      ST_ALIGN: begin
        o_bus_rw = 1'b1;
      end
      // The index is concatenated rather than added, so the source never carries
      // into the next page.
      ST_READ: begin
        o_bus_addr = {i_page, i_idx};
        o_bus_rw   = 1'b1;
      end
      ST_WRITE: begin
        o_bus_addr     = OAM_DATA_ADDR;
        o_bus_data_out = i_dma_data;
        o_bus_rw       = 1'b0;
      end
      default: begin
        o_bus_addr     = i_cpu_addr;
        o_bus_data_out = i_cpu_data_out;
        o_bus_rw       = i_cpu_rw;
      end
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - 2A03 sprite DMA ($4014) bus arbiter and sequencer
//
// Purpose : Sits between the CPU core and the system bus. A CPU write to the DMA
//           register halts the core (o_cpu_rdy=0), then copies XFER_LEN bytes from
//           page {data,8'h00} to OAM_DATA_ADDR as alternating get/put cycles, then
//           returns the bus to the CPU.
// Config  : OAM_DMA_ALIGN_EN defined   -> an ALIGN cycle is inserted when needed so
//                                         every get cycle lands on apu_phase 0.
//           OAM_DMA_ALIGN_EN undefined -> HALT always goes straight to READ.
// Ports   :
//   i_clock        in  1   system clock (CPU rate)
//   i_reset        in  1   synchronous, active-high reset
//   i_cpu_addr     in  16  address driven by the CPU core
//   i_cpu_data_out in  8   write data from the CPU core
//   i_cpu_rw       in  1   CPU direction (1=read, 0=write)
//   i_mem_data_in  in  8   read data returned by the bus
//   o_bus_addr     out 16  arbitrated bus address
//   o_bus_data_out out 8   arbitrated write data
//   o_bus_rw       out 1   arbitrated direction (1=read, 0=write)
//   o_cpu_rdy      out 1   0 = CPU must stall on its next read cycle
//   o_dma_active   out 1   1 while the DMA owns the bus (ALIGN/READ/WRITE)
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR,
  parameter int          XFER_LEN      = DEF_XFER_LEN
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data_out,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_mem_data_in,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_data_out,
  output logic        o_bus_rw,
  output logic        o_cpu_rdy,
  output logic        o_dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_dma_data;
  logic       r_apu_phase;   // 0 = get cycle, 1 = put cycle
  logic       w_dma_trigger;
  logic       w_last_byte;

  assign w_dma_trigger = !i_cpu_rw && (i_cpu_addr == DMA_REG_ADDR);
  assign w_last_byte   = (r_idx == LAST_IDX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 8'd0;
      r_page      <= 8'd0;
      r_dma_data  <= 8'd0;
      r_apu_phase <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_apu_phase <= ~r_apu_phase;
      // Page is only captured from IDLE; later $4014 writes during HALT are ignored.
      if ((r_state == ST_IDLE) && w_dma_trigger) begin
        r_page <= i_cpu_data_out;
        r_idx  <= 8'd0;
      end
      if (r_state == ST_READ) begin
        r_dma_data <= i_mem_data_in;
      end
      if (r_state == ST_WRITE) begin
        r_idx <= w_last_byte ? 8'd0 : r_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dma_trigger) begin
          w_next_state = ST_HALT;
        end
      end
      // A CPU write cannot be stalled, so wait here until the core issues a read;
      // that read cycle is the halt cycle.
      ST_HALT: begin
        if (i_cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
          // Current phase 1 means the next cycle is a get cycle.
          w_next_state = r_apu_phase ? ST_READ : ST_ALIGN;
`else
          w_next_state = ST_READ;
`endif
        end
      end
      ST_ALIGN: w_next_state = ST_READ;
      ST_READ:  w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = w_last_byte ? ST_IDLE : ST_READ;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign o_cpu_rdy    = (r_state == ST_IDLE);
  assign o_dma_active = dma_owns_bus(r_state);

  oam_dma_bus_mux #(
    .OAM_DATA_ADDR (OAM_DATA_ADDR)
  ) u_bus_mux (
    .i_state        (r_state),
    .i_cpu_addr     (i_cpu_addr),
    .i_cpu_data_out (i_cpu_data_out),
    .i_cpu_rw       (i_cpu_rw),
    .i_page         (r_page),
    .i_idx          (r_idx),
    .i_dma_data     (r_dma_data),
    .o_bus_addr     (o_bus_addr),
    .o_bus_data_out (o_bus_data_out),
    .o_bus_rw       (o_bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw;
  logic [7:0]  mem_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rw;
  logic        cpu_rdy;
  logic        dma_active;

  always #5 clk = ~clk;

`ifdef OAM_DMA_ALIGN_EN
  localparam int EXP_ODD_LOW   = 514;
  localparam int EXP_ODD_ALIGN = 1;
`else
  localparam int EXP_ODD_LOW   = 513;
  localparam int EXP_ODD_ALIGN = 0;
`endif

  oam_dma_arbiter dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_data_out (cpu_data_out),
    .i_cpu_rw       (cpu_rw),
    .i_mem_data_in  (mem_data_in),
    .o_bus_addr     (bus_addr),
    .o_bus_data_out (bus_data_out),
    .o_bus_rw       (bus_rw),
    .o_cpu_rdy      (cpu_rdy),
    .o_dma_active   (dma_active)
  );

  // Memory contents: page $02 holds i^$5A at $0200+i; other pages differ so a wrong
  // page shows up in both address and data.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  assign mem_data_in = mem_byte(bus_addr);

  int n_vec = 0;
  int n_bad = 0;
  bit tb_phase = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply CPU inputs for the current cycle and move to the sampling point.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_addr     = a;
    cpu_data_out = d;
    cpu_rw       = rw;
    @(negedge clk);
  endtask

  // Commit the cycle; track the APU phase the DUT should have in the new cycle.
  task automatic adv();
    @(posedge clk);
    if (reset) tb_phase = 1'b0;
    else       tb_phase = ~tb_phase;
    #1;
  endtask

  task automatic run_xfer(input string nm, input logic [7:0] page, input bit want_phase,
                          input int n_extra, input int exp_low, input int exp_align);
    int low = 0, n_align = 0, nrd = 0, nwr = 0;
    int rd_err = 0, wr_err = 0, pass_err = 0, ph_err = 0;
    bit done = 0;
    int guard = 0;
    while (tb_phase != want_phase && guard < 4) begin
      drive(16'h8000, 8'h00, 1'b1);
      adv();
      guard++;
    end
    drive(16'h4014, page, 1'b0);
    check_val({nm, "_trig_rdy"}, 32'(cpu_rdy), 32'd1);
    adv();
    for (int i = 0; i < n_extra; i++) begin
      drive(16'h4014, 8'h07, 1'b0);
      if (!cpu_rdy) low++;
      if (dma_active || bus_addr !== 16'h4014 || bus_rw !== 1'b0 || bus_data_out !== 8'h07)
        pass_err++;
      adv();
    end
    for (int c = 0; c < 1200 && !done; c++) begin
      drive(16'h8000, 8'hEE, 1'b1);
      if (cpu_rdy) begin
        done = 1;
      end else begin
        low++;
        if (dma_active) begin
          if (bus_rw) begin
            if (bus_addr == 16'h8000) begin
              n_align++;
            end else begin
              if (bus_addr !== {page, 8'(nrd)}) rd_err++;
              if (tb_phase != 1'b0) ph_err++;
              nrd++;
            end
          end else begin
            if (bus_addr !== 16'h2004 || bus_data_out !== mem_byte({page, 8'(nwr)})) wr_err++;
            nwr++;
          end
        end else if (bus_addr !== 16'h8000 || bus_rw !== 1'b1 || bus_data_out !== 8'hEE) begin
          pass_err++;
        end
        adv();
      end
    end
    check_val({nm, "_released"}, 32'(done), 32'd1);
    check_val({nm, "_low_cycles"}, 32'(low), 32'(exp_low));
    check_val({nm, "_align"}, 32'(n_align), 32'(exp_align));
    check_val({nm, "_reads"}, 32'(nrd), 32'd256);
    check_val({nm, "_writes"}, 32'(nwr), 32'd256);
    check_val({nm, "_rd_addr_err"}, 32'(rd_err), 32'd0);
    check_val({nm, "_wr_err"}, 32'(wr_err), 32'd0);
    check_val({nm, "_pass_err"}, 32'(pass_err), 32'd0);
    check_val({nm, "_end_active"}, 32'(dma_active), 32'd0);
`ifdef OAM_DMA_ALIGN_EN
    check_val({nm, "_read_phase"}, 32'(ph_err), 32'd0);
`endif
    adv();
  endtask

  initial begin
    int nwr;
    int late_wr;
    int late_act;
    reset = 1'b1;
    cpu_addr = 16'h8000;
    cpu_data_out = 8'h00;
    cpu_rw = 1'b1;
    adv();
    adv();
    reset = 1'b0;

    // 1: passthrough after reset
    for (int i = 0; i < 4; i++) begin
      drive(16'h8000 + 16'(i * 3), 8'h11, 1'b1);
      check_val($sformatf("t1_addr%0d", i), 32'(bus_addr), 32'h8000 + 32'(i * 3));
      check_val($sformatf("t1_rdy%0d", i), 32'(cpu_rdy), 32'd1);
      check_val($sformatf("t1_act%0d", i), 32'(dma_active), 32'd0);
      adv();
    end
    drive(16'h4015, 8'h3C, 1'b0);
    check_val("t1_wr_rw", 32'(bus_rw), 32'd0);
    check_val("t1_wr_data", 32'(bus_data_out), 32'h3C);
    adv();
    drive(16'h4014, 8'h02, 1'b1);
    adv();
    drive(16'h8000, 8'h00, 1'b1);
    check_val("t1_nearmiss_rdy", 32'(cpu_rdy), 32'd1);
    adv();

    // 2: trigger on phase 0 -> 513 stalled cycles
    run_xfer("t2", 8'h02, 1'b0, 0, 513, 0);
    // 3/6: trigger on phase 1 -> ALIGN cycle only when alignment is enabled
    run_xfer("t3", 8'h03, 1'b1, 0, EXP_ODD_LOW, EXP_ODD_ALIGN);
    // 4: two extra writes hold HALT; 3 HALT cycles + 512 transfer cycles
    run_xfer("t4", 8'h02, 1'b0, 2, 515, 0);

    // 5: reset after 100 bytes
    nwr = 0;
    drive(16'h4014, 8'h05, 1'b0);
    adv();
    for (int c = 0; c < 400 && nwr < 100; c++) begin
      drive(16'h8000, 8'h00, 1'b1);
      if (dma_active && !bus_rw) nwr++;
      adv();
    end
    check_val("t5_bytes_before", 32'(nwr), 32'd100);
    reset = 1'b1;
    drive(16'h8000, 8'h00, 1'b1);
    adv();
    reset = 1'b0;
    drive(16'h8123, 8'h44, 1'b1);
    check_val("t5_active", 32'(dma_active), 32'd0);
    check_val("t5_rdy", 32'(cpu_rdy), 32'd1);
    check_val("t5_addr", 32'(bus_addr), 32'h8123);
    check_val("t5_data", 32'(bus_data_out), 32'h44);
    adv();
    late_wr = 0;
    late_act = 0;
    for (int c = 0; c < 600; c++) begin
      drive(16'h8000, 8'h00, 1'b1);
      if (bus_addr == 16'h2004 && !bus_rw) late_wr++;
      if (dma_active || !cpu_rdy) late_act++;
      adv();
    end
    check_val("t5_late_writes", 32'(late_wr), 32'd0);
    check_val("t5_late_active", 32'(late_act), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
